op_sequencer: RTL and testbench
===============================

# op_sequencer

Command sequencer in front of the matrix `controller`. It buffers 32-bit operation words from the host in a small queue and drives them onto `controller.operation` one at a time, holding each for exactly the cycles it needs. It gates `controller.enable` to give back-pressure on serial page write and read. It inserts an idle gap after every operation so the controller's rising-edge detect on `opcode == 1` always sees a fresh edge.

## Interface
- `DEPTH`, 4 — command queue entries (power of 2, ≥2).
- `MM_LEN`, 96 — cycles an `opcode 1` (matmul) word is held, covering shift-in plus pipeline drain.
- `XFER_LEN`, 128 — data beats per `opcode 2` (page write) or `opcode 3` (page read).
- `clk` in 1 — clock.
- `reset` in 1 — synchronous, active-high.
- `enable` in 1 — global enable; when low all state freezes.
- `cmd_valid` in 1 — host command valid.
- `cmd_ready` out 1 — queue not full.
- `cmd` in 32 — operation word, same encoding as the controller (`[3:0]` opcode).
- `wr_valid` in 1 — host write beat valid.
- `wr_ready` out 1 — sequencer accepts a write beat.
- `wr_data` in 32 — write beat payload.
- `rd_valid` out 1 — read beat valid.
- `rd_ready` in 1 — host accepts a read beat.
- `rd_data` out 32 — read beat payload.
- `operation` out 32 — to `controller.operation`.
- `ctl_enable` out 1 — to `controller.enable`.
- `ctl_in_data` out 32 — to `controller.in_data`.
- `ctl_out_data` in 32 — from `controller.out_data`.
- `busy` out 1 — state ≠ IDLE or queue non-empty.
- `done` out 1 — one-cycle pulse when an operation's GAP cycle completes.
- `err` out 1 — sticky; set on an illegal opcode, cleared only by reset.
- `perf_ops` out 16 — see Configuration.
- `perf_stall` out 32 — see Configuration.

## Operation
- States: IDLE, MM, WR, RD, GAP. A beat counter is `$clog2(max(MM_LEN, XFER_LEN))` bits wide.
- **IDLE**
  - Queue non-empty: pop the head and register it into `operation`.
  - Next state by opcode: 1 → MM, 2 → WR, 3 → RD, 0 → GAP (NOP).
  - Opcodes 4–15: discarded, `err` is set, state stays IDLE, `operation` stays 0.
- **MM**
  - `ctl_enable = enable`.
  - Counter increments every enabled cycle; at `MM_LEN-1` go to GAP.
- **WR**
  - `wr_ready = 1`, `ctl_in_data = wr_data`, `ctl_enable = enable & wr_valid`.
  - Each `wr_valid` cycle is one beat; after beat `XFER_LEN-1` go to GAP.
- **RD**
  - `rd_valid = 1`, `rd_data = ctl_out_data` (combinational), `ctl_enable = enable & rd_ready`.
  - Each `rd_ready` cycle is one beat; after beat `XFER_LEN-1` go to GAP.
- **GAP**
  - `operation = 0`, `ctl_enable = enable` for exactly one cycle.
  - Pulse `done`, then go to IDLE.
- In IDLE, `ctl_enable = enable` and `operation = 0`.
- `wr_ready` and `rd_valid` are 0 outside WR and RD respectively.
- `cmd_ready = !full && !reset`. A push while full is not possible; push and pop in the same cycle are both honoured.
- The `operation` word is held unchanged for the whole MM, WR or RD phase. Fields other than the opcode are passed through uninterpreted.

## Timing
- Reset values: `operation = 0`, `ctl_enable = 0` during the reset cycle, `busy = 0`, `done = 0`, `err = 0`, `wr_ready = 0`, `rd_valid = 0`, queue empty, counter = 0, state = IDLE.
- Command accepted at edge E:
  - It is visible at the queue head after E.
  - `operation` carries it after edge E+1 when the sequencer is IDLE.
- MM occupies exactly `MM_LEN` enabled cycles, followed by 1 GAP cycle.
- Back-to-back matmuls are therefore separated by ≥2 cycles with `opcode ≠ 1` (GAP plus IDLE).
- WR and RD have zero added latency per beat. Stalled cycles hold the counter and drop `ctl_enable`, so the controller's serial pointer does not advance.
- `enable = 0` freezes state, counter, queue and `err`. It forces `ctl_enable = 0`, `wr_ready = 0` and `rd_valid = 0`.
- Reset mid-operation:
  - Abort to IDLE and flush the queue.
  - The controller's own reset is shared. No partial-page recovery is attempted.

## Configuration
- `OPSEQ_PERF_EN` defined:
  - `perf_ops` counts issued opcode-1 words, wrapping at 2^16.
  - `perf_stall` counts WR/RD cycles with `ctl_enable = 0` while `enable = 1`, saturating at 2^32−1.
  - Both cleared by reset.
- Not defined: both ports are tied to 0 and no counter flops are built.

## Structure
- Package `opseq_pkg` holds:
  - state enum `opseq_state_t`;
  - opcode constants `OP_IDLE = 0`, `OP_MM = 1`, `OP_WR = 2`, `OP_RD = 3`;
  - opcode field slice `OPCODE_MSB = 3`, `OPCODE_LSB = 0`.
- Sub-module `opseq_fifo`: a synchronous FIFO parameterised by width and depth, with `full`/`empty` outputs. The top-level FSM, counter and muxing stay in `op_sequencer`.

## Test plan
- Push `0x0000_0001` (MM) after reset with `MM_LEN = 96`:
  - `operation = 0x1` for exactly 96 cycles starting 2 edges after acceptance;
  - then 1 cycle of 0 with `done = 1`;
  - `busy` falls afterwards.
- Push 2 MM words back to back: `operation` is 0 for exactly 2 cycles between the two 96-cycle windows.
- WR of 128 beats with `wr_valid` toggling every other cycle: 256 cycles in WR, `ctl_enable` mirrors `wr_valid`, `ctl_in_data` equals `wr_data` on every beat.
- RD with `rd_ready` held low for 10 cycles mid-transfer: the counter holds, `ctl_enable = 0` for those 10 cycles, and exactly 128 beats are delivered.
- Fill the queue with 4 commands while MM is running: `cmd_ready = 0` on the 5th attempt. Push `0x0000_0007`: `err` sets and the word is skipped with `operation` unchanged.
- Assert `reset` for 1 cycle in the middle of WR: the next cycle shows state IDLE, queue empty, `operation = 0`, `wr_ready = 0`. With `OPSEQ_PERF_EN`, `perf_stall = 0`.

Source files
------------

// File: rtl/opseq_pkg.sv
// Shared types and constants for the op_sequencer command sequencer.
package opseq_pkg;

  // Sequencer phases
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MM,
    ST_WR,
    ST_RD,
    ST_GAP
  } opseq_state_t;

  // Controller opcodes understood by the sequencer
  localparam logic [3:0] OP_IDLE = 4'd0;
  localparam logic [3:0] OP_MM   = 4'd1;
  localparam logic [3:0] OP_WR   = 4'd2;
  localparam logic [3:0] OP_RD   = 4'd3;

  // Opcode field position inside an operation word
  localparam int OPCODE_MSB = 3;
  localparam int OPCODE_LSB = 0;

endpackage

// File: rtl/opseq_fifo.sv
// Synchronous FIFO for queued operation words.
// Push is ignored when full and pop is ignored when empty.
// Push and pop in the same cycle are both honoured.
module opseq_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer and occupancy update
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Control registers; reset flushes the queue
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array write
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; the cleared count guarantees stale entries are never read.
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/op_sequencer.sv
// Command sequencer in front of the matrix controller.
// Buffers host operation words, holds each on `operation` for as long as it
// needs, gates the controller enable for serial page write/read back-pressure,
// and inserts one idle GAP cycle after every operation.
// Optional performance counters are built when OPSEQ_PERF_EN is defined.
module op_sequencer
  import opseq_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int MM_LEN   = 96,
  parameter int XFER_LEN = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [31:0] wr_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [31:0] rd_data,
  output logic [31:0] operation,
  output logic        ctl_enable,
  output logic [31:0] ctl_in_data,
  input  logic [31:0] ctl_out_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] perf_ops,
  output logic [31:0] perf_stall
);

  localparam int CNT_MAX = (MM_LEN > XFER_LEN) ? MM_LEN : XFER_LEN;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] MM_LAST   = CNT_W'(MM_LEN - 1);
  localparam logic [CNT_W-1:0] XFER_LAST = CNT_W'(XFER_LEN - 1);

  opseq_state_t state_q, state_d;
  logic [31:0]  op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic         err_q, err_d;

  logic         fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [31:0]  fifo_head;
  logic [OPCODE_MSB-OPCODE_LSB:0] head_opc;
  logic         live;
  logic         xfer_beat;

  opseq_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (cmd),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Controller-facing strobes are only live outside reset and while enabled
  assign live      = enable && !reset;
  assign cmd_ready = !fifo_full && !reset;
  assign fifo_push = cmd_valid && cmd_ready && enable;
  assign head_opc  = fifo_head[OPCODE_MSB:OPCODE_LSB];
  assign operation = op_q;
  assign rd_data   = ctl_out_data;
  assign err       = err_q;
  assign busy      = (state_q != ST_IDLE) || !fifo_empty;

  // Next-state, beat counting and output muxing
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    fifo_pop    = 1'b0;
    ctl_enable  = 1'b0;
    ctl_in_data = '0;
    wr_ready    = 1'b0;
    rd_valid    = 1'b0;
    done        = 1'b0;
    xfer_beat   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ctl_enable = live;
        if (enable && !fifo_empty) begin
          fifo_pop = 1'b1;
          case (head_opc)
            OP_MM: begin
              state_d = ST_MM;
              op_d    = fifo_head;
            end
            OP_WR: begin
              state_d = ST_WR;
              op_d    = fifo_head;
            end
            OP_RD: begin
              state_d = ST_RD;
              op_d    = fifo_head;
            end
            OP_IDLE: begin
              state_d = ST_GAP;
              op_d    = '0;
            end
            default: err_d = 1'b1;
          endcase
        end
      end

      ST_MM: begin
        ctl_enable = live;
        if (enable) begin
          if (cnt_q == MM_LAST) begin
            state_d = ST_GAP;
            cnt_d   = '0;
            op_d    = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      ST_WR: begin
        wr_ready    = live;
        ctl_in_data = wr_data;
        ctl_enable  = live && wr_valid;
        xfer_beat   = enable && wr_valid;
      end

      ST_RD: begin
        rd_valid   = live;
        ctl_enable = live && rd_ready;
        xfer_beat  = enable && rd_ready;
      end

      ST_GAP: begin
        ctl_enable = live;
        done       = live;
        if (enable) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // Shared beat counter for page write and page read
    if (xfer_beat) begin
      if (cnt_q == XFER_LAST) begin
        state_d = ST_GAP;
        cnt_d   = '0;
        op_d    = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers; reset aborts any operation
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

`ifdef OPSEQ_PERF_EN
  logic [15:0] perf_ops_q, perf_ops_d;
  logic [31:0] perf_stall_q, perf_stall_d;
  logic        mm_issue, xfer_stall;

  // Issued matmuls (wrapping) and stalled transfer cycles (saturating)
  always_comb begin
    mm_issue     = enable && (state_q == ST_IDLE) && !fifo_empty && (head_opc == OP_MM);
    xfer_stall   = enable && (((state_q == ST_WR) && !wr_valid) ||
                              ((state_q == ST_RD) && !rd_ready));
    perf_ops_d   = mm_issue ? perf_ops_q + 16'd1 : perf_ops_q;
    perf_stall_d = (xfer_stall && (perf_stall_q != '1)) ? perf_stall_q + 32'd1 : perf_stall_q;
  end

  // Performance counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_ops_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_ops_q   <= perf_ops_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_ops   = perf_ops_q;
  assign perf_stall = perf_stall_q;
`else
  assign perf_ops   = '0;
  assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_op_sequencer.sv
// Self-checking bench for op_sequencer: directed scenarios plus randomized
// traffic compared every cycle against a transaction-level reference model.
module tb_op_sequencer;

  localparam int DEPTH    = 4;
  localparam int MM_LEN   = 96;
  localparam int XFER_LEN = 128;

  logic        clk = 1'b0;
  logic        reset, enable, cmd_valid, wr_valid, rd_ready;
  logic [31:0] cmd, wr_data, ctl_out_data;
  logic        cmd_ready, wr_ready, rd_valid, ctl_enable, busy, done, err;
  logic [31:0] rd_data, operation, ctl_in_data, perf_stall;
  logic [15:0] perf_ops;

  op_sequencer #(
    .DEPTH    (DEPTH),
    .MM_LEN   (MM_LEN),
    .XFER_LEN (XFER_LEN)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd          (cmd),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_data      (wr_data),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_data      (rd_data),
    .operation    (operation),
    .ctl_enable   (ctl_enable),
    .ctl_in_data  (ctl_in_data),
    .ctl_out_data (ctl_out_data),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .perf_ops     (perf_ops),
    .perf_stall   (perf_stall)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pending words, the active operation with beats left,
  // and a pending idle-gap flag.
  logic [31:0] mq[$];
  logic [31:0] m_word = '0;
  int          m_kind = 0;     // opcode of the active operation, 0 = none
  int          m_left = 0;
  bit          m_gap  = 1'b0;
  bit          m_err  = 1'b0;
  logic [15:0] m_ops  = '0;
  logic [31:0] m_stall = '0;

  // Observations from the latest sampled cycle
  logic [31:0] s_op;
  logic        s_cmd_ready, s_busy, s_err, s_wr_ready;

  // Directed-scenario statistics, taken from DUT outputs
  int st_cyc, st_op1, st_done, st_first_op1, st_done_at;
  int st_wrrdy, st_beats, st_stall_cyc;
  int mm_windows, zero_run, last_gap;
  bit prev_op1;

  task automatic clear_stats();
    st_cyc = 0; st_op1 = 0; st_done = 0; st_first_op1 = -1; st_done_at = -1;
    st_wrrdy = 0; st_beats = 0; st_stall_cyc = 0;
    mm_windows = 0; zero_run = 0; last_gap = -1; prev_op1 = 1'b0;
  endtask

  task automatic sample_and_check();
    bit beat_ok;
    bit op1;
    beat_ok = (m_kind == 2) ? wr_valid : (m_kind == 3) ? rd_ready : 1'b1;
    check("cmd_ready", cmd_ready, !reset && (mq.size() < DEPTH));
    check("ctl_enable", ctl_enable, !reset && enable && beat_ok);
    if (!reset) begin
      check("operation", operation, (m_kind != 0) ? m_word : 32'h0);
      check("wr_ready", wr_ready, enable && (m_kind == 2));
      check("rd_valid", rd_valid, enable && (m_kind == 3));
      if (m_kind == 2) check("ctl_in_data", ctl_in_data, wr_data);
      if (m_kind == 3) check("rd_data", rd_data, ctl_out_data);
      check("done", done, enable && m_gap);
      check("busy", busy, (m_kind != 0) || m_gap || (mq.size() != 0));
      check("err", err, m_err);
`ifdef OPSEQ_PERF_EN
      check("perf_ops", perf_ops, m_ops);
      check("perf_stall", perf_stall, m_stall);
`else
      check("perf_ops", perf_ops, 32'h0);
      check("perf_stall", perf_stall, 32'h0);
`endif
    end
    s_op = operation; s_cmd_ready = cmd_ready; s_busy = busy; s_err = err; s_wr_ready = wr_ready;
    op1 = (operation == 32'h1);
    if (op1) begin
      st_op1++;
      if (st_first_op1 < 0) st_first_op1 = st_cyc;
      if (!prev_op1) begin
        if (mm_windows > 0) last_gap = zero_run;
        mm_windows++;
      end
      zero_run = 0;
    end else begin
      zero_run++;
    end
    prev_op1 = op1;
    if (done) begin
      st_done++;
      if (st_done_at < 0) st_done_at = st_cyc;
    end
    if (wr_ready) st_wrrdy++;
    if ((wr_ready && wr_valid) || (rd_valid && rd_ready)) st_beats++;
    if ((wr_ready || rd_valid) && !ctl_enable) st_stall_cyc++;
    st_cyc++;
  endtask

  task automatic model_step();
    int          sz;
    bit          push, beat;
    logic [31:0] w;
    logic [3:0]  opc;
    if (reset) begin
      mq.delete();
      m_kind = 0; m_left = 0; m_gap = 1'b0; m_err = 1'b0; m_ops = '0; m_stall = '0;
      return;
    end
    if (!enable) return;
    sz   = mq.size();
    push = cmd_valid && (sz < DEPTH);
    if (m_gap) begin
      m_gap = 1'b0;
    end else if (m_kind != 0) begin
      beat = (m_kind == 1) || (m_kind == 2 && wr_valid) || (m_kind == 3 && rd_ready);
      if (!beat && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (beat) begin
        m_left--;
        if (m_left == 0) begin
          m_kind = 0;
          m_gap  = 1'b1;
        end
      end
    end else if (sz > 0) begin
      w   = mq.pop_front();
      opc = w[3:0];
      if (opc == 4'd0) begin
        m_gap = 1'b1;
      end else if (opc <= 4'd3) begin
        m_kind = int'(opc);
        m_word = w;
        m_left = (opc == 4'd1) ? MM_LEN : XFER_LEN;
        if (opc == 4'd1) m_ops++;
      end else begin
        m_err = 1'b1;
      end
    end
    if (push) mq.push_back(cmd);
  endtask

  task automatic cycle();
    @(negedge clk);
    sample_and_check();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    cmd = w;
    cmd_valid = 1'b1;
    cycle();
    cmd_valid = 1'b0;
  endtask

  function automatic bit model_busy();
    return (m_kind != 0) || m_gap || (mq.size() != 0);
  endfunction

  task automatic run_until_idle(input int budget, input string tag);
    int n = 0;
    while (model_busy() && n < budget) begin
      cycle();
      n++;
    end
    check({tag, "_in_budget"}, n < budget, 1'b1);
    cycle();
    check({tag, "_busy_after"}, s_busy, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] r;
    logic [3:0]  opc;
    int          k;

    reset = 1'b1; enable = 1'b1; cmd_valid = 1'b0; cmd = '0;
    wr_valid = 1'b0; rd_ready = 1'b0; wr_data = '0; ctl_out_data = '0;
    clear_stats();
    cycle();
    cycle();
    reset = 1'b0;
    cycle();
    check("rst_operation", s_op, 32'h0);
    check("rst_busy", s_busy, 1'b0);
    check("rst_err", s_err, 1'b0);

    // Single matmul: 96 cycles of opcode 1 from two edges after acceptance, then GAP
    clear_stats();
    push(32'h0000_0001);
    run_until_idle(300, "mm1");
    check("mm1_len", st_op1, MM_LEN);
    check("mm1_start", st_first_op1, 2);
    check("mm1_done_cnt", st_done, 1);
    check("mm1_done_at", st_done_at, 2 + MM_LEN);

    // Back-to-back matmuls: exactly two non-matmul cycles between windows
    clear_stats();
    push(32'h0000_0001);
    push(32'h0000_0001);
    run_until_idle(500, "mm2");
    check("mm2_windows", mm_windows, 2);
    check("mm2_gap", last_gap, 2);
    check("mm2_len", st_op1, 2 * MM_LEN);

    // Enable low for 5 cycles mid-matmul stretches the visible window by 5
    clear_stats();
    push(32'h0000_0001);
    for (int i = 0; i < 30; i++) cycle();
    enable = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    enable = 1'b1;
    run_until_idle(300, "mm_frz");
    check("mm_frz_len", st_op1, MM_LEN + 5);

    // Page write with wr_valid toggling every other cycle
    clear_stats();
    push(32'hA5A5_0002);
    cycle();
    k = 0;
    while (m_kind != 0 && k < 600) begin
      wr_valid = k[0];
      wr_data  = $urandom;
      cycle();
      k++;
    end
    wr_valid = 1'b0;
    check("wr_cycles", st_wrrdy, 2 * XFER_LEN);
    check("wr_beats", st_beats, XFER_LEN);
    run_until_idle(20, "wr");

    // Page read with rd_ready low for 10 cycles mid-transfer
    clear_stats();
    push(32'h0000_1233);
    cycle();
    k = 0;
    while (m_kind != 0 && k < 600) begin
      rd_ready     = !(k >= 40 && k < 50);
      ctl_out_data = $urandom;
      cycle();
      k++;
    end
    rd_ready = 1'b0;
    check("rd_beats", st_beats, XFER_LEN);
    check("rd_stalls", st_stall_cyc, 10);
    run_until_idle(20, "rd");

    // Fill the queue while a matmul runs, then an illegal opcode sets err
    push(32'h0000_0001);
    cycle();
    push(32'h0000_0000);
    push(32'h0000_0007);
    push(32'h0000_0100);
    push(32'h0000_0000);
    cmd = 32'h0000_0002;
    cmd_valid = 1'b1;
    cycle();
    cmd_valid = 1'b0;
    check("full_cmd_ready", s_cmd_ready, 1'b0);
    check("err_before", s_err, 1'b0);
    run_until_idle(300, "fill");
    check("err_after", s_err, 1'b1);

    // Reset in the middle of a page write
    push(32'h0000_0002);
    cycle();
    for (int i = 0; i < 20; i++) begin
      wr_valid = (i % 3) != 0;
      wr_data  = $urandom;
      cycle();
    end
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    wr_valid = 1'b0;
    cycle();
    check("rst_mid_wr_ready", s_wr_ready, 1'b0);
    check("rst_mid_busy", s_busy, 1'b0);
    check("rst_mid_op", s_op, 32'h0);
    check("rst_mid_err", s_err, 1'b0);
`ifdef OPSEQ_PERF_EN
    check("rst_mid_perf_stall", perf_stall, 32'h0);
`endif

    // Randomized traffic against the reference model
    for (int i = 0; i < 12000; i++) begin
      enable    = ($urandom % 16) != 0;
      reset     = ($urandom % 1500) == 0;
      cmd_valid = ($urandom % 6) == 0;
      k = $urandom % 16;
      if (k < 4)       opc = 4'd1;
      else if (k < 8)  opc = 4'd2;
      else if (k < 12) opc = 4'd3;
      else if (k < 14) opc = 4'd0;
      else             opc = 4'(4 + ($urandom % 12));
      r = $urandom;
      cmd          = {r[31:4], opc};
      wr_valid     = ($urandom % 4) != 0;
      rd_ready     = ($urandom % 4) != 0;
      wr_data      = $urandom;
      ctl_out_data = $urandom;
      cycle();
    end
    reset = 1'b0; enable = 1'b1; cmd_valid = 1'b0; wr_valid = 1'b1; rd_ready = 1'b1;
    run_until_idle(3000, "drain");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
